commit_stage_mp: RTL and testbench
==================================

COMMIT_STAGE_MP -- requirements
Module: commit_stage_mp

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 4, legal range 1..8, giving the number of scoreboard commit ports.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 1023, giving the drain-wait cycle count before timeout is flagged.
REQ-003 SHALL have clk_i, in, 1: the single clock.
REQ-004 SHALL have rst_i, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have halt_i / single_step_i, in, 1 each: halt request / single-step debug mode.
REQ-006 SHALL have commit_instr_i, in, scoreboard_entry_t[N]: in-order heads; port 0 is oldest.
REQ-007 SHALL have commit_ack_o, out, N: per-port retire acknowledge.
REQ-008 SHALL have we_gpr_o / we_fpr_o, out, N each, plus waddr_o (N x 5) and wdata_o (N x 64): register-file write ports.
REQ-009 SHALL have commit_lsu_o, out, 1, with commit_lsu_ready_i and no_st_pending_i, in, 1 each.
REQ-010 SHALL have amo_resp_i, in, amo_resp_t, and amo_valid_commit_o, out, 1.
REQ-011 SHALL have csr_exception_i, in, exception_t, csr_rdata_i, in, 64, and commit_csr_o, out, 1.
REQ-012 SHALL have exception_o, out, exception_t: trap to controller.
REQ-013 SHALL have fence_o, fence_i_o, sfence_vma_o and flush_commit_o, out, 1 each: single-cycle pulses.
REQ-014 SHALL have csr_write_fflags_o, out, 1, and fflags_o, out, 5.
REQ-015 SHALL have retire_cnt_o, out, $clog2(N+1): instructions acked this cycle.
REQ-016 SHALL have instret_o, out, 64, and drain_timeout_o, out, 1.

Function
REQ-017 SHALL implement FSM states IDLE, DRAIN, AMO_WAIT.
REQ-018 In IDLE, the head (port 0) SHALL be acked when valid, !ex.valid and !halt_i, unless another rule withholds the ack.
REQ-019 A STORE non-AMO head SHALL ack and pulse commit_lsu_o only when commit_lsu_ready_i=1.
REQ-020 A CSR head SHALL ack, assert commit_csr_o and write csr_rdata_i, and only when csr_exception_i.valid=0.
REQ-021 A FENCE, FENCE_I or SFENCE_VMA head SHALL move IDLE->DRAIN with no ack that cycle.
REQ-022 In DRAIN, the first cycle with no_st_pending_i=1 SHALL ack port 0, pulse the matching fence_o, fence_i_o or sfence_vma_o, and return to IDLE.
REQ-023 An AMO head SHALL move IDLE->AMO_WAIT; amo_valid_commit_o=1 throughout AMO_WAIT.
REQ-024 In AMO_WAIT, amo_resp_i.ack=1 SHALL ack port 0, set we_gpr_o[0] with wdata_o[0]=amo_resp_i.result, pulse flush_commit_o, and return to IDLE.
REQ-025 Port i>0 SHALL ack only if all of these hold:
- ports 0..i-1 acked this cycle;
- port i valid and !ex.valid;
- fu is ALU, LOAD, CTRL_FLOW, MULT, FPU or FPU_VEC;
- head is not CSR, AMO or fence-class;
- single_step_i=0 and halt_i=0.
REQ-026 Each acked port SHALL drive we_fpr_o if is_rd_fpr(op), otherwise we_gpr_o; unacked ports drive no write enable.
REQ-027 fflags_o SHALL be the OR of ex.cause[4:0] over acked FPU/FPU_VEC ports; csr_write_fflags_o=1 iff any such port exists.
REQ-028 retire_cnt_o SHALL be the popcount of commit_ack_o; instret_o SHALL add retire_cnt_o on each clock edge and wrap modulo 2^64.
REQ-029 A drain counter SHALL clear on DRAIN entry and saturate at DRAIN_TIMEOUT; drain_timeout_o=1 while in DRAIN with the counter saturated.
REQ-030 exception_o SHALL be driven in IDLE only, when port 0 is valid:
- commit_instr_i[0].ex takes priority;
- otherwise csr_exception_i, with tval replaced by port 0 ex.tval;
- valid is forced to 0 when halt_i=1.
REQ-031 halt_i SHALL NOT abort DRAIN or AMO_WAIT; it only blocks new acks from IDLE.

Reset
REQ-032 rst_i=1 SHALL force state IDLE, instret_o=0, drain counter=0 and drain_timeout_o=0, effective immediately and asynchronously, including mid-DRAIN or mid-AMO_WAIT.
REQ-033 During reset, all ack, write-enable and pulse outputs SHALL be 0.

Structure
REQ-034 The commit FSM state enum and the function is_serialising(fu_op) SHALL live in ariane_pkg.
REQ-035 Sub-module commit_drain_ctrl SHALL contain the FSM and the drain counter; the per-port ack chain and the fflags merge stay in the top level.

Verification
REQ-036 Four valid ALU heads, no exceptions -> commit_ack_o=4'b1111, retire_cnt_o=4, instret_o +4 on the next edge.
REQ-037 Port 0 ALU, port 1 STORE, ports 2-3 ALU -> commit_ack_o=4'b0001.
REQ-038 FENCE head with no_st_pending_i low for 5 cycles -> no ack in those cycles; on the cycle it goes high, ack[0]=1 and fence_o pulses for exactly one cycle.
REQ-039 AMO head with amo_resp_i.ack after 3 cycles, result=64'hDEAD -> amo_valid_commit_o high for 3 cycles, then wdata_o[0]=64'hDEAD and flush_commit_o pulses.
REQ-040 Two FPU ports with causes 5'b00001 and 5'b10000 -> fflags_o=5'b10001 and csr_write_fflags_o=1.
REQ-041 DRAIN_TIMEOUT=8, FENCE head, no_st_pending_i held low, rst_i asserted after 10 cycles -> drain_timeout_o=1 from cycle 8, then immediate IDLE and all outputs 0 on reset.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared commit-stage types: scoreboard entries, exceptions, AMO responses,
// the commit FSM state and opcode classification helpers.
package ariane_pkg;

    typedef enum logic [3:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
    } fu_t;

    typedef enum logic [4:0] {
        ADD, SUB, LD, SD, JAL, MUL, CSRRW, FENCE, FENCE_I, SFENCE_VMA,
        AMO_ADD, AMO_SWAP, FADD, FMUL, FLD, FCMP
    } fu_op;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic        ack;
        logic [63:0] result;
    } amo_resp_t;

    typedef struct packed {
        fu_t         fu;
        fu_op        op;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        valid;
        exception_t  ex;
    } scoreboard_entry_t;

    typedef enum logic [1:0] {IDLE, DRAIN, AMO_WAIT} commit_state_e;

    function automatic logic is_serialising(input fu_op op);
        return (op == FENCE) || (op == FENCE_I) || (op == SFENCE_VMA);
    endfunction

    function automatic logic is_amo(input fu_op op);
        return (op == AMO_ADD) || (op == AMO_SWAP);
    endfunction

    function automatic logic is_rd_fpr(input fu_op op);
        return (op == FADD) || (op == FMUL) || (op == FLD);
    endfunction

endpackage

// File: rtl/commit_drain_ctrl.sv
// Commit FSM: serialises fences (wait for store drain) and AMOs (wait for the
// memory response), with a saturating drain-wait counter.
module commit_drain_ctrl
    import ariane_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 1023
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          drain_req_i,
    input  logic          amo_req_i,
    input  logic          no_st_pending_i,
    input  logic          amo_ack_i,
    output commit_state_e state_o,
    output logic          drain_timeout_o
);
    localparam int CW = $clog2(DRAIN_TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_TIMEOUT);

    commit_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Next state and drain counter; the counter restarts on every DRAIN entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (drain_req_i) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (amo_req_i) begin
                    state_d = AMO_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (no_st_pending_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            AMO_WAIT: begin
                if (amo_ack_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = AMO_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
        timeout_d = (state_d == DRAIN) && (cnt_d == CNT_MAX);
    end

    // State, counter and timeout flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_o         = state_q;
    assign drain_timeout_o = timeout_q;

endmodule

// File: rtl/commit_stage_mp.sv
// Multi-port commit stage: retires up to NR_COMMIT_PORTS in-order heads per
// cycle, routing fences and AMOs through commit_drain_ctrl.
module commit_stage_mp
    import ariane_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 4,
    parameter int DRAIN_TIMEOUT   = 1023
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      halt_i,
    input  logic                                      single_step_i,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_instr_i,
    output logic [NR_COMMIT_PORTS-1:0]                commit_ack_o,
    output logic [NR_COMMIT_PORTS-1:0]                we_gpr_o,
    output logic [NR_COMMIT_PORTS-1:0]                we_fpr_o,
    output logic [NR_COMMIT_PORTS-1:0][4:0]           waddr_o,
    output logic [NR_COMMIT_PORTS-1:0][63:0]          wdata_o,
    output logic                                      commit_lsu_o,
    input  logic                                      commit_lsu_ready_i,
    input  logic                                      no_st_pending_i,
    input  amo_resp_t                                 amo_resp_i,
    output logic                                      amo_valid_commit_o,
    input  exception_t                                csr_exception_i,
    input  logic [63:0]                               csr_rdata_i,
    output logic                                      commit_csr_o,
    output exception_t                                exception_o,
    output logic                                      fence_o,
    output logic                                      fence_i_o,
    output logic                                      sfence_vma_o,
    output logic                                      flush_commit_o,
    output logic                                      csr_write_fflags_o,
    output logic [4:0]                                fflags_o,
    output logic [$clog2(NR_COMMIT_PORTS+1)-1:0]      retire_cnt_o,
    output logic [63:0]                               instret_o,
    output logic                                      drain_timeout_o
);
    localparam int CNT_W = $clog2(NR_COMMIT_PORTS + 1);

    commit_state_e              state_s;
    scoreboard_entry_t          head_s;
    logic                       head_ok_s, drain_req_s, amo_req_s;
    logic [NR_COMMIT_PORTS-1:0] ack_s;
    logic [CNT_W-1:0]           retire_cnt_s;
    logic [63:0]                instret_q, instret_d;

    function automatic logic port_retirable(input scoreboard_entry_t e);
        return e.valid && !e.ex.valid && !is_amo(e.op) && !is_serialising(e.op) &&
               (e.fu inside {ALU, LOAD, CTRL_FLOW, MULT, FPU, FPU_VEC});
    endfunction

    assign head_s      = commit_instr_i[0];
    assign head_ok_s   = head_s.valid && !head_s.ex.valid && !halt_i;
    assign drain_req_s = (state_s == IDLE) && head_ok_s && is_serialising(head_s.op);
    assign amo_req_s   = (state_s == IDLE) && head_ok_s && is_amo(head_s.op);

    commit_drain_ctrl #(.DRAIN_TIMEOUT(DRAIN_TIMEOUT)) u_drain_ctrl (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .drain_req_i     (drain_req_s),
        .amo_req_i       (amo_req_s),
        .no_st_pending_i (no_st_pending_i),
        .amo_ack_i       (amo_resp_i.ack),
        .state_o         (state_s),
        .drain_timeout_o (drain_timeout_o)
    );

    // Ack chain and single-cycle pulses; younger ports only ride along with an IDLE ack.
    always_comb begin
        ack_s          = '0;
        commit_lsu_o   = 1'b0;
        commit_csr_o   = 1'b0;
        fence_o        = 1'b0;
        fence_i_o      = 1'b0;
        sfence_vma_o   = 1'b0;
        flush_commit_o = 1'b0;
        case (state_s)
            IDLE: begin
                if (head_ok_s && !drain_req_s && !amo_req_s) begin
                    if (head_s.fu == STORE) begin
                        ack_s[0]     = commit_lsu_ready_i;
                        commit_lsu_o = commit_lsu_ready_i;
                    end else if (head_s.fu == CSR) begin
                        ack_s[0]     = !csr_exception_i.valid;
                        commit_csr_o = !csr_exception_i.valid;
                    end else begin
                        ack_s[0] = 1'b1;
                    end
                end else begin
                    ack_s[0] = 1'b0;
                end
                for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
                    ack_s[i] = ack_s[i-1] && port_retirable(commit_instr_i[i]) &&
                               !single_step_i && !halt_i;
                end
            end
            DRAIN: begin
                if (no_st_pending_i) begin
                    ack_s[0]     = 1'b1;
                    fence_o      = (head_s.op == FENCE);
                    fence_i_o    = (head_s.op == FENCE_I);
                    sfence_vma_o = (head_s.op == SFENCE_VMA);
                end else begin
                    ack_s[0] = 1'b0;
                end
            end
            AMO_WAIT: begin
                if (amo_resp_i.ack) begin
                    ack_s[0]       = 1'b1;
                    flush_commit_o = 1'b1;
                end else begin
                    ack_s[0] = 1'b0;
                end
            end
            default: ack_s = '0;
        endcase
        if (rst_i) begin
            ack_s          = '0;
            commit_lsu_o   = 1'b0;
            commit_csr_o   = 1'b0;
            fence_o        = 1'b0;
            fence_i_o      = 1'b0;
            sfence_vma_o   = 1'b0;
            flush_commit_o = 1'b0;
        end else begin
            ack_s = ack_s;
        end
    end

    // Register-file write ports, fflags merge and retire count.
    always_comb begin
        we_gpr_o           = '0;
        we_fpr_o           = '0;
        fflags_o           = 5'b0;
        csr_write_fflags_o = 1'b0;
        retire_cnt_s       = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            waddr_o[i] = commit_instr_i[i].rd;
            wdata_o[i] = commit_instr_i[i].result;
            if (ack_s[i]) begin
                retire_cnt_s = retire_cnt_s + CNT_W'(1'b1);
                if (is_rd_fpr(commit_instr_i[i].op)) begin
                    we_fpr_o[i] = 1'b1;
                end else begin
                    we_gpr_o[i] = 1'b1;
                end
                if (commit_instr_i[i].fu inside {FPU, FPU_VEC}) begin
                    fflags_o           = fflags_o | commit_instr_i[i].ex.cause[4:0];
                    csr_write_fflags_o = 1'b1;
                end else begin
                    csr_write_fflags_o = csr_write_fflags_o;
                end
            end else begin
                retire_cnt_s = retire_cnt_s;
            end
        end
        if (state_s == AMO_WAIT) begin
            wdata_o[0] = amo_resp_i.result;
        end else if ((state_s == IDLE) && (head_s.fu == CSR)) begin
            wdata_o[0] = csr_rdata_i;
        end else begin
            wdata_o[0] = head_s.result;
        end
    end

    // Trap report: head exception wins, else the CSR file's exception with the head's tval.
    always_comb begin
        exception_o = '0;
        if ((state_s == IDLE) && head_s.valid) begin
            if (head_s.ex.valid) begin
                exception_o = head_s.ex;
            end else begin
                exception_o      = csr_exception_i;
                exception_o.tval = head_s.ex.tval;
            end
            exception_o.valid = exception_o.valid && !halt_i;
        end else begin
            exception_o = '0;
        end
    end

    assign instret_d = instret_q + 64'(retire_cnt_s);

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instret_q <= 64'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign commit_ack_o       = ack_s;
    assign retire_cnt_o       = retire_cnt_s;
    assign instret_o          = instret_q;
    assign amo_valid_commit_o = (state_s == AMO_WAIT);

endmodule

// File: tb/tb_commit_stage_mp.sv
// Self-checking bench for commit_stage_mp: directed scenarios then randomized
// heads, all compared against a behavioural commit model.
module tb_commit_stage_mp;
    import ariane_pkg::*;

    localparam int N = 4;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst, halt, single_step, lsu_ready, no_st;
    scoreboard_entry_t [N-1:0] instr;
    amo_resp_t  amo_resp;
    exception_t csr_ex, exc;
    logic [63:0] csr_rdata, instret;
    logic [N-1:0] ack, we_gpr, we_fpr;
    logic [N-1:0][4:0]  waddr;
    logic [N-1:0][63:0] wdata;
    logic commit_lsu, amo_valid, commit_csr, fence, fence_i, sfence, flush, wff, timeout;
    logic [4:0] fflags;
    logic [2:0] retire_cnt;

    always #5 clk = ~clk;

    commit_stage_mp #(.NR_COMMIT_PORTS(N), .DRAIN_TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst), .halt_i(halt), .single_step_i(single_step),
        .commit_instr_i(instr), .commit_ack_o(ack), .we_gpr_o(we_gpr), .we_fpr_o(we_fpr),
        .waddr_o(waddr), .wdata_o(wdata), .commit_lsu_o(commit_lsu),
        .commit_lsu_ready_i(lsu_ready), .no_st_pending_i(no_st), .amo_resp_i(amo_resp),
        .amo_valid_commit_o(amo_valid), .csr_exception_i(csr_ex), .csr_rdata_i(csr_rdata),
        .commit_csr_o(commit_csr), .exception_o(exc), .fence_o(fence), .fence_i_o(fence_i),
        .sfence_vma_o(sfence), .flush_commit_o(flush), .csr_write_fflags_o(wff),
        .fflags_o(fflags), .retire_cnt_o(retire_cnt), .instret_o(instret),
        .drain_timeout_o(timeout)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int m_mode   = 0;   // 0 idle, 1 waiting for stores to drain, 2 waiting for AMO
    int m_dcnt   = 0;
    longint unsigned m_instret = 0;
    longint unsigned base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_fence(fu_op op);
        return op == FENCE || op == FENCE_I || op == SFENCE_VMA;
    endfunction
    function automatic bit tb_amo(fu_op op);
        return op == AMO_ADD || op == AMO_SWAP;
    endfunction
    function automatic bit tb_fpr(fu_op op);
        return op == FADD || op == FMUL || op == FLD;
    endfunction
    function automatic bit tb_young_ok(scoreboard_entry_t e);
        return e.valid && !e.ex.valid && !tb_amo(e.op) && !tb_fence(e.op) &&
               (e.fu inside {ALU, LOAD, CTRL_FLOW, MULT, FPU, FPU_VEC});
    endfunction

    function automatic scoreboard_entry_t mk(fu_t fu, fu_op op, logic [63:0] res, logic [4:0] rd);
        scoreboard_entry_t e = '0;
        e.fu = fu; e.op = op; e.result = res; e.rd = rd; e.valid = 1'b1;
        return e;
    endfunction

    function automatic scoreboard_entry_t rnd_instr();
        scoreboard_entry_t e;
        case ($urandom_range(0, 15))
            0: e = mk(ALU, ADD, 64'd0, 5'd0);        1: e = mk(ALU, SUB, 64'd0, 5'd0);
            2: e = mk(LOAD, LD, 64'd0, 5'd0);        3: e = mk(LOAD, FLD, 64'd0, 5'd0);
            4: e = mk(STORE, SD, 64'd0, 5'd0);       5: e = mk(CTRL_FLOW, JAL, 64'd0, 5'd0);
            6: e = mk(MULT, MUL, 64'd0, 5'd0);       7: e = mk(FPU, FADD, 64'd0, 5'd0);
            8: e = mk(FPU, FCMP, 64'd0, 5'd0);       9: e = mk(FPU_VEC, FMUL, 64'd0, 5'd0);
            10: e = mk(CSR, CSRRW, 64'd0, 5'd0);     11: e = mk(CSR, FENCE, 64'd0, 5'd0);
            12: e = mk(CSR, FENCE_I, 64'd0, 5'd0);   13: e = mk(CSR, SFENCE_VMA, 64'd0, 5'd0);
            14: e = mk(STORE, AMO_ADD, 64'd0, 5'd0); default: e = mk(LOAD, AMO_SWAP, 64'd0, 5'd0);
        endcase
        e.result   = {$urandom, $urandom};
        e.rd       = 5'($urandom);
        e.valid    = ($urandom_range(0, 7) != 0);
        e.ex.valid = ($urandom_range(0, 15) == 0);
        e.ex.cause = {32'd0, $urandom};
        e.ex.tval  = {$urandom, $urandom};
        return e;
    endfunction

    task automatic clear_inputs();
        instr = '0; halt = 1'b0; single_step = 1'b0; lsu_ready = 1'b1; no_st = 1'b0;
        amo_resp = '0; csr_ex = '0; csr_rdata = 64'hC5C5_0000_1234_5678;
    endtask

    task automatic reset_model();
        m_mode = 0; m_dcnt = 0; m_instret = 0;
    endtask

    // One clock: compare every output against the model at negedge, then advance the model.
    task automatic cycle();
        logic [N-1:0] e_ack, e_gpr, e_fpr;
        logic [4:0]   e_ff;
        logic [63:0]  e_wd0, e_cause, e_tval;
        bit e_wff, e_lsu, e_csr, e_fen, e_feni, e_sfen, e_flush, e_exv;
        scoreboard_entry_t h;
        @(negedge clk);
        h = instr[0];
        e_ack = '0; e_gpr = '0; e_fpr = '0; e_ff = 5'd0; e_wff = 0;
        e_lsu = 0; e_csr = 0; e_fen = 0; e_feni = 0; e_sfen = 0; e_flush = 0;
        e_wd0 = h.result;
        if (!rst) begin
            if (m_mode == 0) begin
                if (h.valid && !h.ex.valid && !halt && !tb_fence(h.op) && !tb_amo(h.op)) begin
                    if (h.fu == STORE) begin
                        e_ack[0] = lsu_ready; e_lsu = lsu_ready;
                    end else if (h.fu == CSR) begin
                        e_ack[0] = !csr_ex.valid; e_csr = !csr_ex.valid; e_wd0 = csr_rdata;
                    end else e_ack[0] = 1'b1;
                end
                if (e_ack[0] && !single_step)
                    for (int i = 1; i < N; i++) begin
                        if (!tb_young_ok(instr[i])) break;
                        e_ack[i] = 1'b1;
                    end
            end else if (m_mode == 1) begin
                if (no_st) begin
                    e_ack[0] = 1'b1; e_fen = (h.op == FENCE);
                    e_feni = (h.op == FENCE_I); e_sfen = (h.op == SFENCE_VMA);
                end
            end else if (amo_resp.ack) begin
                e_ack[0] = 1'b1; e_flush = 1; e_wd0 = amo_resp.result;
            end
            for (int i = 0; i < N; i++)
                if (e_ack[i]) begin
                    if (tb_fpr(instr[i].op)) e_fpr[i] = 1'b1; else e_gpr[i] = 1'b1;
                    if (instr[i].fu == FPU || instr[i].fu == FPU_VEC) begin
                        e_ff = e_ff | instr[i].ex.cause[4:0]; e_wff = 1;
                    end
                end
        end
        e_exv = 0; e_cause = 64'd0; e_tval = 64'd0;
        if (m_mode == 0 && h.valid) begin
            e_exv   = (h.ex.valid || csr_ex.valid) && !halt;
            e_cause = h.ex.valid ? h.ex.cause : csr_ex.cause;
            e_tval  = h.ex.tval;
        end
        chk("ack", 64'(ack), 64'(e_ack));
        chk("retire_cnt", 64'(retire_cnt), 64'($countones(e_ack)));
        chk("we_gpr", 64'(we_gpr), 64'(e_gpr));
        chk("we_fpr", 64'(we_fpr), 64'(e_fpr));
        chk("fflags", 64'(fflags), 64'(e_ff));
        chk("wr_fflags", 64'(wff), 64'(e_wff));
        chk("pulses", {57'd0, commit_lsu, commit_csr, fence, fence_i, sfence, flush, amo_valid},
            {57'd0, e_lsu, e_csr, e_fen, e_feni, e_sfen, e_flush, 1'(!rst && m_mode == 2)});
        chk("drain_timeout", 64'(timeout), 64'(!rst && m_mode == 1 && m_dcnt >= T));
        chk("instret", instret, m_instret);
        chk("exc_valid", 64'(exc.valid), 64'(e_exv));
        if (e_exv) begin
            chk("exc_cause", exc.cause, e_cause);
            chk("exc_tval", exc.tval, e_tval);
        end
        if (e_ack[0]) chk("wdata0", wdata[0], e_wd0);
        for (int i = 1; i < N; i++)
            if (e_ack[i]) begin
                chk("wdata_n", wdata[i], instr[i].result);
                chk("waddr_n", 64'(waddr[i]), 64'(instr[i].rd));
            end
        if (rst) reset_model();
        else begin
            m_instret += 64'($countones(e_ack));
            if (m_mode == 0) begin
                if (h.valid && !h.ex.valid && !halt) begin
                    if (tb_fence(h.op)) begin m_mode = 1; m_dcnt = 0; end
                    else if (tb_amo(h.op)) m_mode = 2;
                end
            end else if (m_mode == 1) begin
                if (no_st) m_mode = 0; else m_dcnt++;
            end else if (amo_resp.ack) m_mode = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        reset_model();
        for (int i = 0; i < N; i++) instr[i] = mk(ALU, ADD, 64'(i), 5'(i + 1));
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_we", 64'({we_gpr, we_fpr}), 64'd0);
        cycle(); cycle();
        chk("rst_instret", instret, 64'd0);
        rst = 1'b0;

        // four ALU heads retire together
        for (int i = 0; i < N; i++) instr[i] = mk(ALU, ADD, 64'(100 + i), 5'(i + 1));
        #1;
        chk("all_alu_ack", 64'(ack), 64'hF);
        chk("all_alu_cnt", 64'(retire_cnt), 64'd4);
        base = m_instret;
        cycle();
        chk("all_alu_instret", instret, base + 64'd4);

        // a store in port 1 stops the chain
        instr[1] = mk(STORE, SD, 64'd7, 5'd3);
        #1 chk("store_p1_ack", 64'(ack), 64'h1);
        cycle();

        // fflags merge over two FPU ports
        clear_inputs();
        instr[0] = mk(FPU, FADD, 64'd1, 5'd1); instr[0].ex.cause = 64'h01;
        instr[1] = mk(FPU, FCMP, 64'd2, 5'd2); instr[1].ex.cause = 64'h10;
        #1;
        chk("fpu_fflags", 64'(fflags), 64'h11);
        chk("fpu_wff", 64'(wff), 64'd1);
        chk("fpu_we_fpr", 64'(we_fpr), 64'h1);
        cycle();

        // halt blocks, single-step limits to port 0
        for (int i = 0; i < N; i++) instr[i] = mk(ALU, ADD, 64'(i), 5'(i));
        halt = 1'b1;
        #1 chk("halt_ack", 64'(ack), 64'd0);
        cycle();
        halt = 1'b0; single_step = 1'b1;
        #1 chk("step_ack", 64'(ack), 64'h1);
        cycle();

        // CSR head: exception withholds ack, tval comes from the head
        clear_inputs();
        instr[0] = mk(CSR, CSRRW, 64'd9, 5'd4); instr[0].ex.tval = 64'h1234;
        csr_ex.valid = 1'b1; csr_ex.cause = 64'd2; csr_ex.tval = 64'h55;
        #1;
        chk("csr_ex_ack", 64'(ack), 64'd0);
        chk("csr_ex_tval", exc.tval, 64'h1234);
        cycle();
        csr_ex = '0;
        #1;
        chk("csr_ack", 64'(commit_csr), 64'd1);
        chk("csr_wdata", wdata[0], csr_rdata);
        cycle();

        // fence waits for the store buffer
        clear_inputs();
        instr[0] = mk(CSR, FENCE, 64'd0, 5'd0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            #1 chk("fence_wait_ack", 64'(ack), 64'd0);
            cycle();
        end
        no_st = 1'b1;
        #1;
        chk("fence_ack", 64'(ack), 64'h1);
        chk("fence_pulse", 64'(fence), 64'd1);
        cycle();
        instr = '0;
        #1 chk("fence_pulse_end", 64'(fence), 64'd0);
        cycle();

        // AMO waits three cycles for its response
        clear_inputs();
        instr[0] = mk(STORE, AMO_ADD, 64'd0, 5'd6);
        cycle();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("amo_valid_wait", 64'(amo_valid), 64'd1);
            chk("amo_wait_ack", 64'(ack), 64'd0);
            cycle();
        end
        amo_resp.ack = 1'b1; amo_resp.result = 64'hDEAD;
        #1;
        chk("amo_wdata", wdata[0], 64'hDEAD);
        chk("amo_flush", 64'(flush), 64'd1);
        chk("amo_we", 64'(we_gpr), 64'h1);
        cycle();
        clear_inputs();
        #1 chk("amo_flush_end", 64'(flush), 64'd0);
        cycle();

        // drain timeout then asynchronous reset mid-DRAIN
        instr[0] = mk(CSR, SFENCE_VMA, 64'd0, 5'd0);
        cycle();
        for (int j = 0; j <= 10; j++) begin
            #1 chk("timeout_seq", 64'(timeout), 64'(j >= T));
            cycle();
        end
        rst = 1'b1;
        reset_model();
        #1;
        chk("rst_drain_timeout", 64'(timeout), 64'd0);
        chk("rst_drain_ack", 64'(ack), 64'd0);
        chk("rst_drain_instret", instret, 64'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // asynchronous reset mid-AMO_WAIT
        clear_inputs();
        instr[0] = mk(LOAD, AMO_SWAP, 64'd0, 5'd2);
        cycle(); cycle();
        rst = 1'b1;
        reset_model();
        #1 chk("rst_amo_valid", 64'(amo_valid), 64'd0);
        cycle();
        rst = 1'b0;
        clear_inputs();
        cycle();

        // randomized heads; operands held while the FSM is busy
        for (int n = 0; n < 400; n++) begin
            halt = ($urandom_range(0, 9) == 0);
            if (m_mode == 0) begin
                for (int i = 0; i < N; i++) instr[i] = rnd_instr();
                single_step = ($urandom_range(0, 7) == 0);
                lsu_ready   = ($urandom_range(0, 3) != 0);
                csr_ex      = '0;
                csr_ex.valid = ($urandom_range(0, 3) == 0);
                csr_ex.cause = {32'd0, $urandom};
                csr_ex.tval  = {$urandom, $urandom};
                csr_rdata    = {$urandom, $urandom};
            end
            no_st = ($urandom_range(0, 3) == 0);
            amo_resp.ack    = ($urandom_range(0, 2) == 0);
            amo_resp.result = {$urandom, $urandom};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
